// File: rtl/alien_collision_ctrl.sv
// Collision/death controller: per-pixel bullet-vs-alien kills, per-frame player contact, lives, death freeze, game over.
// Optional build macro ALIEN_INVULN_EN adds a post-respawn grace period during which player contact is ignored.
module alien_collision_ctrl #(
  parameter int LIVES_INIT   = 3,
  parameter int DEATH_FRAMES = 60
`ifdef ALIEN_INVULN_EN
  ,
  parameter int GRACE_FRAMES = 90
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       alien_dr,
  input  logic       player_dr,
  input  logic       bullet_dr,
  output logic       alien_died,
  output logic       bullet_hit,
  output logic       score_pulse,
  output logic       player_died,
  output logic [2:0] lives,
  output logic       game_over,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    DYING = 2'd1,
    OVER  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       kill_latch_q, kill_latch_d;
  logic       touch_latch_q, touch_latch_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] cnt_q, cnt_d;
  logic       score_pulse_q;
  logic       player_died_q, player_died_d;
  logic       game_over_q, game_over_d;
  logic       in_play;
  logic       contact;
  logic       touch;
  logic       grace_on;

`ifdef ALIEN_INVULN_EN
  logic [7:0] grace_q, grace_d;
  assign grace_on = (grace_q != 8'd0);
`else
  assign grace_on = 1'b0;
`endif

  assign in_play    = (state_q == PLAY);
  // Zero latency: the alien block routes this strobe using its own pixel-local request.
  assign alien_died = alien_dr & bullet_dr & ~kill_latch_q & in_play;
  assign bullet_hit = alien_died;
  assign contact    = alien_dr & player_dr & in_play & ~grace_on;
  assign touch      = touch_latch_q | contact;

  always_comb begin
    state_d       = state_q;
    kill_latch_d  = kill_latch_q;
    touch_latch_d = touch_latch_q;
    lives_d       = lives_q;
    cnt_d         = cnt_q;
`ifdef ALIEN_INVULN_EN
    grace_d       = grace_q;
`endif
    if (startOfFrame) begin
      kill_latch_d  = alien_died;
      touch_latch_d = 1'b0;
`ifdef ALIEN_INVULN_EN
      if (grace_q != 8'd0) grace_d = grace_q - 8'd1;
`endif
      case (state_q)
        PLAY: begin
          // Contact on this cycle still belongs to the frame that is closing.
          if (touch) begin
            state_d = DYING;
            lives_d = lives_q - 3'd1;
            cnt_d   = 8'd0;
          end
        end
        DYING: begin
          if (cnt_q == 8'(DEATH_FRAMES - 1)) begin
            state_d = (lives_q != 3'd0) ? PLAY : OVER;
`ifdef ALIEN_INVULN_EN
            if (lives_q != 3'd0) grace_d = 8'(GRACE_FRAMES);
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end else begin
      kill_latch_d  = kill_latch_q | alien_died;
      touch_latch_d = touch_latch_q | contact;
    end
    player_died_d = (state_d == DYING);
    game_over_d   = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= PLAY;
      kill_latch_q  <= 1'b0;
      touch_latch_q <= 1'b0;
      lives_q       <= 3'(LIVES_INIT);
      cnt_q         <= 8'd0;
      score_pulse_q <= 1'b0;
      player_died_q <= 1'b0;
      game_over_q   <= 1'b0;
`ifdef ALIEN_INVULN_EN
      grace_q       <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      kill_latch_q  <= kill_latch_d;
      touch_latch_q <= touch_latch_d;
      lives_q       <= lives_d;
      cnt_q         <= cnt_d;
      score_pulse_q <= alien_died;
      player_died_q <= player_died_d;
      game_over_q   <= game_over_d;
`ifdef ALIEN_INVULN_EN
      grace_q       <= grace_d;
`endif
    end
  end

  assign score_pulse = score_pulse_q;
  assign player_died = player_died_q;
  assign lives       = lives_q;
  assign game_over   = game_over_q;
  assign dbg_state   = state_q;

endmodule
